// File: rtl/rvfi_dii_sequencer.sv
// Schedules RVFI-DII host commands onto the core's injection port and returns one
// token per retirement, plus a halt token after each drain/core-reset sequence.
module rvfi_dii_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 2,
  parameter int SEQ_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_is_reset,
  input  logic [31:0]      cmd_instr,
  output logic             inj_valid,
  output logic [31:0]      inj_instr,
  input  logic             inj_ready,
  input  logic             ret_valid,
  input  logic             ret_trap,
  output logic             core_rst,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_halt,
  output logic             rsp_trap,
  output logic [SEQ_W-1:0] rsp_seq,
  output logic             busy,
  output logic             err
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, RSTC, ACK} state_t;

  typedef struct packed {
    logic             halt;
    logic             trap;
    logic [SEQ_W-1:0] seq;
  } rsp_t;

  state_t           state;
  logic [RCW-1:0]   rst_cnt;
  logic [CW-1:0]    ostd;
  logic [SEQ_W-1:0] seq;

  // instruction FIFO
  logic [31:0]      imem [FIFO_DEPTH];
  logic [AW-1:0]    iwr, ird;
  logic [CW-1:0]    icnt;
  logic             iempty, ifull, ipush, ipop;

  // response FIFO
  rsp_t             rmem [FIFO_DEPTH];
  logic [AW-1:0]    rwr, rrd;
  logic [CW-1:0]    rcnt;
  logic             rempty, rpush, rpop;
  logic             ret_ok, ack_push, credit_ok;
  rsp_t             rdin, rhead;

  assign iempty = (icnt == '0);
  assign ifull  = (icnt == DEPTH_CNT);
  assign rempty = (rcnt == '0);

  // Every injected instruction owns a response slot until its token is dequeued,
  // so the response FIFO can never overflow.
  assign credit_ok = ({1'b0, ostd} + {1'b0, rcnt}) < DEPTH_EXT;

  assign cmd_ready = (state == RUN) && (cmd_is_reset || !ifull);
  assign ipush     = cmd_valid && cmd_ready && !cmd_is_reset;
  assign inj_valid = !iempty && (state == RUN || state == DRAIN) && credit_ok;
  assign ipop      = inj_valid && inj_ready;
  assign inj_instr = iempty ? '0 : imem[ird];

  assign ret_ok   = ret_valid && (ostd != '0);
  assign ack_push = (state == ACK) && (rcnt != DEPTH_CNT);
  assign rpush    = ret_ok || ack_push;
  assign rdin     = '{halt: ack_push, trap: ret_trap & ~ack_push, seq: seq};

  assign rhead     = rmem[rrd];
  assign rsp_valid = !rempty;
  assign rpop      = rsp_valid && rsp_ready;
  assign rsp_halt  = rsp_valid & rhead.halt;
  assign rsp_trap  = rsp_valid & rhead.trap;
  assign rsp_seq   = rsp_valid ? rhead.seq : '0;

  assign busy = (state != RUN) || !iempty || (ostd != '0);

  always_ff @(posedge clk) begin
    if (ipush) imem[iwr] <= cmd_instr;
    if (rpush) rmem[rwr] <= rdin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iwr  <= '0;
      ird  <= '0;
      icnt <= '0;
      rwr  <= '0;
      rrd  <= '0;
      rcnt <= '0;
      ostd <= '0;
    end else begin
      if (ipush) iwr <= iwr + 1'b1;
      if (ipop)  ird <= ird + 1'b1;
      icnt <= icnt + CW'(ipush) - CW'(ipop);
      if (rpush) rwr <= rwr + 1'b1;
      if (rpop)  rrd <= rrd + 1'b1;
      rcnt <= rcnt + CW'(rpush) - CW'(rpop);
      ostd <= ostd + CW'(ipop) - CW'(ret_ok);
    end
  end

  // Dequeuing the halt token starts a fresh trace numbering.
  always_ff @(posedge clk) begin
    if (rst)                   seq <= '0;
    else if (rpop && rhead.halt) seq <= '0;
    else if (rpush)            seq <= seq + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          err <= 1'b0;
    else if (ret_valid && ostd == '0) err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      rst_cnt  <= '0;
      core_rst <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cmd_valid && cmd_is_reset) state <= DRAIN;
        end
        DRAIN: begin
          if (iempty && ostd == '0) begin
            state    <= RSTC;
            core_rst <= 1'b1;
            rst_cnt  <= RCW'(RST_CYCLES - 1);
          end
        end
        RSTC: begin
          if (rst_cnt == '0) begin
            state    <= ACK;
            core_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        ACK: begin
          if (ack_push) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_dii_sequencer.sv
// Bench for rvfi_dii_sequencer: directed scenarios plus a randomized run checked
// against a queue-based reference model of the host/core protocol.
module tb_rvfi_dii_sequencer;
  localparam int D  = 4;
  localparam int RC = 2;
  localparam int SW = 16;
  localparam int P_RUN = 0, P_DRAIN = 1, P_RSTC = 2, P_ACK = 3;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, cmd_is_reset, inj_valid, inj_ready;
  logic ret_valid, ret_trap, core_rst, rsp_valid, rsp_ready, rsp_halt, rsp_trap, busy, err;
  logic [31:0]   cmd_instr, inj_instr;
  logic [SW-1:0] rsp_seq;

  always #5 clk = ~clk;

  rvfi_dii_sequencer #(.FIFO_DEPTH(D), .RST_CYCLES(RC), .SEQ_W(SW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_reset(cmd_is_reset), .cmd_instr(cmd_instr), .inj_valid(inj_valid),
    .inj_instr(inj_instr), .inj_ready(inj_ready), .ret_valid(ret_valid),
    .ret_trap(ret_trap), .core_rst(core_rst), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_halt(rsp_halt), .rsp_trap(rsp_trap),
    .rsp_seq(rsp_seq), .busy(busy), .err(err)
  );

  typedef struct { bit halt; bit trap; int seq; } tok_t;

  // reference model: queues for the two FIFOs, plain counters for the rest
  bit [31:0] m_iq[$];
  tok_t      m_rq[$];
  int        m_out, m_seq, m_phase, m_rc;
  bit        m_err;

  logic          e_cmd_ready, e_inj_valid, e_core_rst, e_rsp_valid, e_rsp_halt, e_rsp_trap, e_busy, e_err;
  logic [31:0]   e_inj_instr;
  logic [SW-1:0] e_rsp_seq;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void calc();
    e_cmd_ready = (m_phase == P_RUN) && (cmd_is_reset || m_iq.size() < D);
    e_inj_valid = (m_iq.size() > 0) && (m_phase <= P_DRAIN) && ((m_out + m_rq.size()) < D);
    e_inj_instr = (m_iq.size() > 0) ? m_iq[0] : 32'h0;
    e_core_rst  = (m_phase == P_RSTC);
    e_rsp_valid = (m_rq.size() > 0);
    e_rsp_halt  = (m_rq.size() > 0) ? m_rq[0].halt : 1'b0;
    e_rsp_trap  = (m_rq.size() > 0) ? m_rq[0].trap : 1'b0;
    e_rsp_seq   = (m_rq.size() > 0) ? m_rq[0].seq[SW-1:0] : '0;
    e_busy      = (m_phase != P_RUN) || (m_iq.size() > 0) || (m_out > 0);
    e_err       = m_err;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // move to the next negative edge.
  task automatic cyc();
    tok_t t;
    bit   hpop, pushed;
    int   pre_i, pre_r, pre_out;
    calc();
    if (rst) begin
      m_iq.delete(); m_rq.delete();
      m_out = 0; m_seq = 0; m_phase = P_RUN; m_rc = 0; m_err = 0;
    end else begin
      hpop = 0; pushed = 0;
      pre_i = m_iq.size(); pre_r = m_rq.size(); pre_out = m_out;
      if (pre_r > 0 && rsp_ready) begin hpop = m_rq[0].halt; void'(m_rq.pop_front()); end
      if (e_inj_valid && inj_ready) begin void'(m_iq.pop_front()); m_out++; end
      if (m_phase == P_RUN && cmd_valid && !cmd_is_reset && pre_i < D) m_iq.push_back(cmd_instr);
      if (ret_valid) begin
        if (pre_out > 0) begin
          t.halt = 0; t.trap = ret_trap; t.seq = m_seq;
          m_rq.push_back(t); m_out--; pushed = 1;
        end else m_err = 1;
      end
      case (m_phase)
        P_RUN:   if (cmd_valid && cmd_is_reset) m_phase = P_DRAIN;
        P_DRAIN: if (pre_i == 0 && pre_out == 0) begin m_phase = P_RSTC; m_rc = RC; end
        P_RSTC:  begin m_rc--; if (m_rc == 0) m_phase = P_ACK; end
        default: if (pre_r < D) begin
          t.halt = 1; t.trap = 0; t.seq = m_seq;
          m_rq.push_back(t); pushed = 1; m_phase = P_RUN;
        end
      endcase
      m_seq = hpop ? 0 : (m_seq + int'(pushed)) % (1 << SW);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cmd_valid = 0; cmd_is_reset = 0; cmd_instr = '0; inj_ready = 0;
    ret_valid = 0; ret_trap = 0; rsp_ready = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); cyc(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++; if ({inj_valid, core_rst, rsp_valid, rsp_halt, rsp_trap, busy, err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000000", {inj_valid, core_rst, rsp_valid, rsp_halt, rsp_trap, busy, err});
    end
    n_cmp++; if (inj_instr !== 32'h0 || rsp_seq !== '0) begin
      n_bad++; $display("FAIL reset_data got instr=%h seq=%h want 0", inj_instr, rsp_seq);
    end
    cyc();
  endtask

  task automatic test_basic();
    logic [31:0] w [2];
    int ci, pi, ti;
    bit rn;
    w[0] = 32'h00100093; w[1] = 32'h00200113;
    do_reset();
    ci = 0; pi = 0; ti = 0; rn = 0;
    inj_ready = 1; rsp_ready = 1;
    for (int c = 0; c < 20; c++) begin
      cmd_valid = (ci < 2); cmd_instr = (ci < 2) ? w[ci] : 32'h0;
      ret_valid = rn; ret_trap = 0;
      #1;
      if (cmd_valid && cmd_ready) ci++;
      rn = inj_valid && inj_ready;
      if (rn && pi < 2) begin
        n_cmp++; if (inj_instr !== w[pi]) begin n_bad++; $display("FAIL basic_inj got %h want %h", inj_instr, w[pi]); end
        pi++;
      end
      if (rsp_valid) begin
        n_cmp++; if ({rsp_halt, rsp_trap, rsp_seq} !== {2'b00, SW'(ti)}) begin
          n_bad++; $display("FAIL basic_tok got h=%b t=%b seq=%0d want h=0 t=0 seq=%0d", rsp_halt, rsp_trap, rsp_seq, ti);
        end
        ti++;
      end
      cyc();
    end
    #1;
    n_cmp++; if (ti !== 2) begin n_bad++; $display("FAIL basic_count got %0d want 2", ti); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b want 0", busy); end
    cyc();
  endtask

  task automatic test_full();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = $urandom();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cmd_valid = 1; cmd_instr = w[c];
      #1;
      n_cmp++; if (cmd_ready !== (c < 4)) begin n_bad++; $display("FAIL full_cmd_ready[%0d] got %b want %b", c, cmd_ready, c < 4); end
      if (c > 0) begin
        n_cmp++; if ({inj_valid, inj_instr} !== {1'b1, w[0]}) begin
          n_bad++; $display("FAIL full_hold[%0d] got v=%b %h want v=1 %h", c, inj_valid, inj_instr, w[0]);
        end
      end
      cyc();
    end
    cmd_valid = 0; inj_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if ({inj_valid, inj_instr} !== {1'b1, w[c]}) begin
        n_bad++; $display("FAIL full_order[%0d] got v=%b %h want v=1 %h", c, inj_valid, inj_instr, w[c]);
      end
      cyc();
    end
  endtask

  task automatic test_credit();
    int ci, np, ti;
    bit rn;
    do_reset();
    ci = 0; np = 0; ti = 0; rn = 0;
    inj_ready = 1;
    for (int c = 0; c < 60; c++) begin
      rsp_ready = (c >= 25);
      cmd_valid = (ci < 6); cmd_instr = 32'h1000 + ci;
      ret_valid = rn; ret_trap = 0;
      #1;
      if (c < 25) begin
        n_cmp++; if (inj_valid !== ((ci - np) > 0 && np < D)) begin
          n_bad++; $display("FAIL credit_inj[%0d] got %b want %b", c, inj_valid, (ci - np) > 0 && np < D);
        end
      end
      rn = inj_valid && inj_ready;
      if (rn) np++;
      if (cmd_valid && cmd_ready) ci++;
      if (rsp_valid && rsp_ready) begin
        n_cmp++; if (rsp_seq !== SW'(ti)) begin n_bad++; $display("FAIL credit_seq got %0d want %0d", rsp_seq, ti); end
        ti++;
      end
      cyc();
    end
    n_cmp++; if (ti !== 6) begin n_bad++; $display("FAIL credit_count got %0d want 6", ti); end
  endtask

  task automatic test_end_of_trace();
    int cr, nt;
    int tseq [8]; bit thalt [8]; bit ttrap [8];
    int xseq [4]; bit xhalt [4]; bit xtrap [4];
    xseq = '{0, 1, 2, 0}; xhalt = '{0, 0, 1, 0}; xtrap = '{1, 0, 0, 0};
    do_reset();
    inj_ready = 1; rsp_ready = 1; cr = 0; nt = 0;
    for (int c = 0; c < 40; c++) begin
      cmd_valid = (c <= 2) || (c == 25); cmd_is_reset = (c == 2);
      cmd_instr = (c == 0) ? 32'h00100093 : (c == 1) ? 32'h00200113 : 32'h00300193;
      ret_valid = (c == 8) || (c == 9) || (c == 28); ret_trap = (c == 8);
      #1;
      if (c == 2) begin
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL eot_accept got %b want 1", cmd_ready); end
      end
      if (c >= 3 && c <= 9) begin
        n_cmp++; if ({cmd_ready, busy, core_rst} !== 3'b010) begin
          n_bad++; $display("FAIL eot_drain[%0d] got rdy/busy/crst=%b want 010", c, {cmd_ready, busy, core_rst});
        end
      end
      if (core_rst) cr++;
      if (rsp_valid && nt < 8) begin
        thalt[nt] = rsp_halt; ttrap[nt] = rsp_trap; tseq[nt] = int'(rsp_seq); nt++;
      end
      cyc();
    end
    n_cmp++; if (cr !== RC) begin n_bad++; $display("FAIL eot_core_rst_cycles got %0d want %0d", cr, RC); end
    n_cmp++; if (nt !== 4) begin n_bad++; $display("FAIL eot_tokens got %0d want 4", nt); end
    for (int i = 0; i < 4 && i < nt; i++) begin
      n_cmp++; if (thalt[i] !== xhalt[i] || ttrap[i] !== xtrap[i] || tseq[i] !== xseq[i]) begin
        n_bad++; $display("FAIL eot_tok[%0d] got h=%b t=%b seq=%0d want h=%b t=%b seq=%0d",
                          i, thalt[i], ttrap[i], tseq[i], xhalt[i], xtrap[i], xseq[i]);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    ret_valid = 1; cyc(); ret_valid = 0;
    #1;
    n_cmp++; if ({err, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL err_set got err/rsp=%b want 10", {err, rsp_valid}); end
    repeat (5) cyc();
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
    rst = 1; cyc(); rst = 0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
    cyc();
  endtask

  task automatic test_rst_in_rstc();
    bit found;
    do_reset();
    inj_ready = 1;
    cmd_valid = 1; cmd_instr = $urandom(); cyc();
    cmd_valid = 0; cyc();
    ret_valid = 1; cyc();
    ret_valid = 0; cmd_valid = 1; cmd_is_reset = 1; cyc();
    cmd_valid = 0; cmd_is_reset = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (core_rst === 1'b1) found = 1; else cyc();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rstc_reach got timeout want core_rst=1"); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rstc_queued got %b want 1", rsp_valid); end
    rst = 1; cyc(); rst = 0;
    #1;
    n_cmp++; if ({core_rst, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rstc_after got crst/rsp/busy/rdy=%b want 0001", {core_rst, rsp_valid, busy, cmd_ready});
    end
    cyc();
    cmd_valid = 1; cmd_instr = 32'h00400213; cyc();
    cmd_valid = 0; cyc();
    ret_valid = 1; cyc();
    ret_valid = 0; rsp_ready = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (rsp_valid === 1'b1) found = 1;
      else cyc();
    end
    n_cmp++; if (!found || {rsp_halt, rsp_seq} !== {1'b0, SW'(0)}) begin
      n_bad++; $display("FAIL rstc_seq got found=%b h=%b seq=%0d want found=1 h=0 seq=0", found, rsp_halt, rsp_seq);
    end
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 255) == 0);
      cmd_valid    = ($urandom_range(0, 1) == 1);
      cmd_is_reset = ($urandom_range(0, 11) == 0);
      cmd_instr    = $urandom();
      inj_ready    = ($urandom_range(0, 9) < 7);
      rsp_ready    = ($urandom_range(0, 9) < 6);
      ret_valid    = (m_out > 0) && ($urandom_range(0, 1) == 1);
      ret_trap     = ($urandom_range(0, 1) == 1);
      #1;
      calc();
      n_cmp++; if ({cmd_ready, inj_valid, core_rst, rsp_valid, busy, err} !==
                   {e_cmd_ready, e_inj_valid, e_core_rst, e_rsp_valid, e_busy, e_err}) begin
        n_bad++; $display("FAIL rand_ctrl[%0d] got %b want %b", c,
          {cmd_ready, inj_valid, core_rst, rsp_valid, busy, err},
          {e_cmd_ready, e_inj_valid, e_core_rst, e_rsp_valid, e_busy, e_err});
      end
      n_cmp++; if (inj_instr !== e_inj_instr) begin
        n_bad++; $display("FAIL rand_inj_instr[%0d] got %h want %h", c, inj_instr, e_inj_instr);
      end
      n_cmp++; if ({rsp_halt, rsp_trap, rsp_seq} !== {e_rsp_halt, e_rsp_trap, e_rsp_seq}) begin
        n_bad++; $display("FAIL rand_rsp[%0d] got h=%b t=%b seq=%0d want h=%b t=%b seq=%0d", c,
          rsp_halt, rsp_trap, rsp_seq, e_rsp_halt, e_rsp_trap, e_rsp_seq);
      end
      cyc();
    end
    rst = 0;
  endtask

  initial begin
    idle(); rst = 1;
    m_out = 0; m_seq = 0; m_phase = P_RUN; m_rc = 0; m_err = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_credit();
    test_end_of_trace();
    test_err();
    test_rst_in_rstc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
